// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Occupancy runs 0..depth inclusive, so it needs one bit more than the address.
    function automatic int count_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic bit thresholds_ok(input int addr_w, input int af_thresh, input int ae_thresh);
        int depth;
        depth = 1 << addr_w;
        return (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module fifo_mem_2p #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost thresholds, sticky
// overflow/underflow flags and a choice of registered or first-word-fall-through read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FWFT_OFF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            rd_en,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_valid,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [count_width(ADDR_W)-1:0]  count,
    output logic                            overflow,
    output logic                            underflow,
    input  logic                            clr_err
);

    localparam int              CW      = count_width(ADDR_W);
    localparam logic [CW-1:0]   DEPTH_C = CW'(1 << ADDR_W);
    localparam logic [CW-1:0]   AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0]   AE_C    = CW'(AE_THRESH);

    if (!thresholds_ok(ADDR_W, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_param: AF_THRESH/AE_THRESH out of range for ADDR_W");
    end
    if ((FWFT != FWFT_OFF) && (FWFT != FWFT_ON)) begin : g_bad_mode
        $error("sync_fifo_param: FWFT must be 0 or 1");
    end

    logic [CW-1:0]     wr_ptr;
    logic [CW-1:0]     rd_ptr;
    logic [CW-1:0]     count_next;
    logic              acc_wr;
    logic              acc_rd;
    logic [DATA_W-1:0] head_data;

    // Accept decisions use the registered flags, so a full FIFO never passes a write through.
    assign acc_wr     = wr_en && !full;
    assign acc_rd     = rd_en && !empty;
    assign count_next = count + CW'(acc_wr) - CW'(acc_rd);

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (acc_wr),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (head_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (acc_wr) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (acc_rd) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);

            // A fresh error in the same cycle as clr_err takes priority.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    if (FWFT == FWFT_ON) begin : g_fwft
        assign rd_data  = head_data;
        assign rd_valid = !empty;
    end else begin : g_reg_read
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= acc_rd;
                if (acc_rd) begin
                    rd_data <= head_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised self-checking bench for sync_fifo_param: a registered-read instance and a
// first-word-fall-through instance, both compared against queue-based reference models.
module tb_sync_fifo_param;

    localparam int DEPTH = 16;

    logic       clk;
    int         checks = 0;
    int         errors = 0;

    // Registered-read instance
    logic       rst_n, wr_en, rd_en, clr_err;
    logic [3:0] wr_data, rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    // FWFT instance
    logic       rst1_n, wr1, rd1, clr1;
    logic [3:0] wdata1, rdata1;
    logic       rvalid1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] count1;

    sync_fifo_param #(.DATA_W(4), .ADDR_W(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_param #(.DATA_W(4), .ADDR_W(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst1_n), .wr_en(wr1), .wr_data(wdata1), .rd_en(rd1),
        .rd_data(rdata1), .rd_valid(rvalid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(unf1), .clr_err(clr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for the registered-read instance
    logic [3:0] mq[$];
    bit         m_ovf, m_unf, m_rvalid;
    logic [3:0] m_rdata;

    // Reference model for the FWFT instance
    logic [3:0] q1[$];
    bit         m1_ovf, m1_unf;

    function automatic void model_reset();
        mq.delete();
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 4'h0;
    endfunction

    function automatic void model_step(input bit w, input logic [3:0] d, input bit r, input bit c);
        int n;
        bit aw, ar;
        n  = mq.size();
        aw = w && (n != DEPTH);
        ar = r && (n != 0);
        if (w && n == DEPTH) m_ovf = 1'b1;
        else if (c)          m_ovf = 1'b0;
        if (r && n == 0)     m_unf = 1'b1;
        else if (c)          m_unf = 1'b0;
        m_rvalid = ar;
        if (ar) m_rdata = mq.pop_front();
        if (aw) mq.push_back(d);
    endfunction

    // {full, empty, almost_full, almost_empty, count} expected from queue occupancy
    function automatic logic [8:0] exp_status();
        int n;
        n = mq.size();
        return {n == DEPTH, n == 0, n >= 14, n <= 2, 5'(n)};
    endfunction

    function automatic void model1_step(input bit w, input logic [3:0] d, input bit r, input bit c);
        int n;
        n = q1.size();
        if (w && n == DEPTH) m1_ovf = 1'b1;
        else if (c)          m1_ovf = 1'b0;
        if (r && n == 0)     m1_unf = 1'b1;
        else if (c)          m1_unf = 1'b0;
        if (r && n != 0)     void'(q1.pop_front());
        if (w && n != DEPTH) q1.push_back(d);
    endfunction

    task automatic drive0(input bit w, input logic [3:0] d, input bit r, input bit c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        model_step(w, d, r, c);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic drive1(input bit w, input logic [3:0] d, input bit r, input bit c);
        wr1    = w;
        wdata1 = d;
        rd1    = r;
        clr1   = c;
        model1_step(w, d, r, c);
        @(posedge clk);
        #1;
        wr1  = 1'b0;
        rd1  = 1'b0;
        clr1 = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({full, empty, almost_full, almost_empty, count} !== 9'b0_1_0_1_00000) begin
            errors++;
            $display("[TB] FAIL reset_status: got %b expected %b",
                     {full, empty, almost_full, almost_empty, count}, 9'b0_1_0_1_00000);
        end
        checks++;
        if ({overflow, underflow, rd_valid, rd_data} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b",
                     {overflow, underflow, rd_valid, rd_data}, 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [3:0] d;
        for (int i = 0; i < 16; i++) begin
            d = (i < 15) ? 4'(i + 1) : 4'hE;
            drive0(1'b1, d, 1'b0, 1'b0);
            checks++;
            if ({full, empty, almost_full, almost_empty, count} !== exp_status()) begin
                errors++;
                $display("[TB] FAIL fill_status[%0d]: got %b expected %b", i,
                         {full, empty, almost_full, almost_empty, count}, exp_status());
            end
            checks++;
            if (rd_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL fill_rd_valid[%0d]: got %b expected 0", i, rd_valid);
            end
        end
        checks++;
        if (full !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("[TB] FAIL fill_full: got full=%b count=%0d expected full=1 count=16", full, count);
        end
        drive0(1'b1, 4'hD, 1'b0, 1'b0);
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_set: got count=%0d ovf=%b expected count=16 ovf=1", count, overflow);
        end
        drive0(1'b0, 4'h0, 1'b0, 1'b1);
        checks++;
        if (overflow !== m_ovf || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            drive0(1'b0, 4'h0, 1'b1, 1'b0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== m_rdata) begin
                errors++;
                $display("[TB] FAIL drain_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, rd_valid, rd_data, m_rdata);
            end
            checks++;
            if ({full, empty, almost_full, almost_empty, count} !== exp_status()) begin
                errors++;
                $display("[TB] FAIL drain_status[%0d]: got %b expected %b", i,
                         {full, empty, almost_full, almost_empty, count}, exp_status());
            end
        end
        checks++;
        if (rd_data !== 4'hE || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_last: got d=%h empty=%b expected d=e empty=1", rd_data, empty);
        end
    endtask

    task automatic test_underflow();
        drive0(1'b0, 4'h0, 1'b1, 1'b0);
        checks++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("[TB] FAIL underflow_set: got unf=%b v=%b count=%0d expected 1 0 0", underflow, rd_valid, count);
        end
        drive0(1'b0, 4'h0, 1'b1, 1'b1);
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow_priority: got %b expected 1", underflow);
        end
        drive0(1'b0, 4'h0, 1'b0, 1'b1);
        checks++;
        if (underflow !== m_unf) begin
            errors++;
            $display("[TB] FAIL underflow_clear: got %b expected %b", underflow, m_unf);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d;
        for (int i = 0; i < 5; i++) begin
            drive0(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        end
        d = 4'h0;
        for (int i = 0; i < 20; i++) begin
            drive0(1'b1, d, 1'b1, 1'b0);
            d = d + 4'h1;
            checks++;
            if (count !== 5'd5 || rd_valid !== 1'b1 || rd_data !== m_rdata) begin
                errors++;
                $display("[TB] FAIL b2b[%0d]: got count=%0d v=%b d=%h expected count=5 v=1 d=%h",
                         i, count, rd_valid, rd_data, m_rdata);
            end
        end
    endtask

    task automatic test_random();
        int wp;
        for (int i = 0; i < 400; i++) begin
            wp = ((i / 100) % 2 == 0) ? 75 : 25;
            drive0($urandom_range(0, 99) < wp, 4'($urandom), $urandom_range(0, 99) < (100 - wp),
                   $urandom_range(0, 19) == 0);
            checks++;
            if ({full, empty, almost_full, almost_empty, count} !== exp_status() ||
                {overflow, underflow} !== {m_ovf, m_unf}) begin
                errors++;
                $display("[TB] FAIL rand_status[%0d]: got %b/%b%b expected %b/%b%b", i,
                         {full, empty, almost_full, almost_empty, count}, overflow, underflow,
                         exp_status(), m_ovf, m_unf);
            end
            checks++;
            if (rd_valid !== m_rvalid || rd_data !== m_rdata) begin
                errors++;
                $display("[TB] FAIL rand_read[%0d]: got v=%b d=%h expected v=%b d=%h", i,
                         rd_valid, rd_data, m_rvalid, m_rdata);
            end
        end
    endtask

    task automatic test_fwft();
        int n;
        @(negedge clk);
        rst1_n = 1'b1;
        drive1(1'b1, 4'hA, 1'b0, 1'b0);
        drive1(1'b1, 4'hB, 1'b0, 1'b0);
        checks++;
        if (rdata1 !== 4'hA || rvalid1 !== 1'b1 || count1 !== 5'd2) begin
            errors++;
            $display("[TB] FAIL fwft_head: got d=%h v=%b count=%0d expected a 1 2", rdata1, rvalid1, count1);
        end
        drive1(1'b0, 4'h0, 1'b1, 1'b0);
        checks++;
        if (rdata1 !== 4'hB || rvalid1 !== 1'b1 || count1 !== 5'd1) begin
            errors++;
            $display("[TB] FAIL fwft_pop: got d=%h v=%b count=%0d expected b 1 1", rdata1, rvalid1, count1);
        end
        for (int i = 0; i < 150; i++) begin
            drive1($urandom_range(0, 99) < 55, 4'($urandom), $urandom_range(0, 99) < 45,
                   $urandom_range(0, 19) == 0);
            n = q1.size();
            checks++;
            if ({full1, empty1, af1, ae1, count1} !== {n == DEPTH, n == 0, n >= 14, n <= 2, 5'(n)} ||
                {ovf1, unf1} !== {m1_ovf, m1_unf} || rvalid1 !== (n != 0)) begin
                errors++;
                $display("[TB] FAIL fwft_status[%0d]: got %b/%b%b/%b expected count=%0d ovf=%b unf=%b",
                         i, {full1, empty1, af1, ae1, count1}, ovf1, unf1, rvalid1, n, m1_ovf, m1_unf);
            end
            if (n != 0) begin
                checks++;
                if (rdata1 !== q1[0]) begin
                    errors++;
                    $display("[TB] FAIL fwft_data[%0d]: got %h expected %h", i, rdata1, q1[0]);
                end
            end
        end
        drive1(1'b1, 4'h7, 1'b0, 1'b0);
        #2;
        rst1_n = 1'b0;
        q1.delete();
        #1;
        checks++;
        if (empty1 !== 1'b1 || count1 !== 5'd0 || rvalid1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fwft_async_reset: got empty=%b count=%0d v=%b expected 1 0 0",
                     empty1, count1, rvalid1);
        end
        @(negedge clk);
        rst1_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        wr_data = 4'h0;
        rst1_n  = 1'b0;
        wr1     = 1'b0;
        rd1     = 1'b0;
        clr1    = 1'b0;
        wdata1  = 4'h0;
        m1_ovf  = 1'b0;
        m1_unf  = 1'b0;
        model_reset();

        test_reset();
        test_fill();
        test_drain();
        test_underflow();
        test_back_to_back();
        test_random();
        test_fwft();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
